// File: rtl/odd_seek_arbiter.sv
// odd_seek_arbiter: round-robin arbiter and seek sequencer for an odd-only
// 4-bit position that wraps 15<->1 and steps by 2 once per DWELL cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   req[1:0]   level request per requester, sampled only in IDLE
//   tgt0/tgt1  target position per requester, latched with the grant
//   grant[1:0] one-hot owner of the position, 0 when idle
//   busy       high whenever the sequencer is not idle
//   done[1:0]  one-cycle pulse to the served requester on arrival
//   err[1:0]   one-cycle pulse when the winning target is even
//   pos[3:0]   current position, always odd
//   dir        direction of the current seek: 1 = up (+2), 0 = down (-2)
//   step       one-cycle pulse in the cycle after pos changed
module odd_seek_arbiter #(
  parameter logic [3:0] RESET_POS = 4'b0001,
  parameter int         DWELL     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] tgt0,
  input  logic [3:0] tgt1,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic [3:0] pos,
  output logic       dir,
  output logic       step
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      pos_nxt;
  logic            dir_nxt;
  logic [1:0]      grant_nxt;
  logic [1:0]      done_nxt;
  logic [1:0]      err_nxt;
  logic            step_nxt;
  logic [CW-1:0]   dwell;
  logic [CW-1:0]   dwell_nxt;
  logic            ptr;
  logic            ptr_nxt;
  logic [3:0]      target;
  logic [3:0]      target_nxt;

  logic            win;
  logic [3:0]      pick;
  logic [2:0]      up_dist;
  logic [1:0]      win_oh;

  assign busy = (state != IDLE);

  // Sole requester wins; on contention ptr names the favoured one.
  assign win     = (req == 2'b11) ? ptr : req[1];
  assign win_oh  = win ? 2'b10 : 2'b01;
  assign pick    = win ? tgt1 : tgt0;
  // Odd values map to index pos[3:1]; the 3-bit difference is the
  // up-distance modulo 8.
  assign up_dist = pick[3:1] - pos[3:1];

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    dir_nxt    = dir;
    grant_nxt  = grant;
    done_nxt   = 2'b00;
    err_nxt    = 2'b00;
    step_nxt   = 1'b0;
    dwell_nxt  = dwell;
    ptr_nxt    = ptr;
    target_nxt = target;
    unique case (state)
      IDLE: begin
        if (|req) begin
          ptr_nxt = ~win;
          if (!pick[0]) begin
            err_nxt = win_oh;
          end else begin
            grant_nxt  = win_oh;
            target_nxt = pick;
            // Distance 4 is a tie; it goes up.
            dir_nxt    = (up_dist <= 3'd4);
            dwell_nxt  = '0;
            state_nxt  = SEEK;
          end
        end
      end
      SEEK: begin
        if (pos == target) begin
          state_nxt = DONE;
          done_nxt  = grant;
        end else if (dwell == LAST) begin
          // 4-bit wrap gives 15+2=1 and 1-2=15 for free.
          pos_nxt   = dir ? pos + 4'd2 : pos - 4'd2;
          dwell_nxt = '0;
          step_nxt  = 1'b1;
        end else begin
          dwell_nxt = dwell + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      pos    <= RESET_POS;
      dir    <= 1'b1;
      grant  <= 2'b00;
      done   <= 2'b00;
      err    <= 2'b00;
      step   <= 1'b0;
      dwell  <= '0;
      ptr    <= 1'b0;
      target <= RESET_POS;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      grant  <= grant_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      step   <= step_nxt;
      dwell  <= dwell_nxt;
      ptr    <= ptr_nxt;
      target <= target_nxt;
    end
  end

endmodule

// File: tb/tb_odd_seek_arbiter.sv
// tb_odd_seek_arbiter: scenario tasks with a scoreboard queue of expected
// seek outcomes for odd_seek_arbiter.
module tb_odd_seek_arbiter;

  localparam int         DWELL     = 2;
  localparam logic [3:0] RESET_POS = 4'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] tgt0 = 4'd0;
  logic [3:0] tgt1 = 4'd0;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] done;
  logic [1:0] err;
  logic [3:0] pos;
  logic       dir;
  logic       step;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] grant;
    logic [3:0] pos;
    logic       dir;
    logic       even;
    int         steps;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] m_pos = RESET_POS;
  logic       m_ptr = 1'b0;

  always #5 clk = ~clk;

  odd_seek_arbiter #(
    .RESET_POS(RESET_POS),
    .DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .tgt0(tgt0),
    .tgt1(tgt1),
    .grant(grant),
    .busy(busy),
    .done(done),
    .err(err),
    .pos(pos),
    .dir(dir),
    .step(step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [1:0] r, input logic [3:0] t0,
                         input logic [3:0] t1, output exp_t e);
    logic       w;
    logic [3:0] t;
    logic [2:0] u;
    w = (r == 2'b11) ? m_ptr : r[1];
    t = w ? t1 : t0;
    u = t[3:1] - m_pos[3:1];
    e.grant = w ? 2'b10 : 2'b01;
    e.even  = ~t[0];
    e.pos   = t[0] ? t : m_pos;
    e.dir   = (u <= 3'd4);
    e.steps = t[0] ? ((u <= 3'd4) ? int'(u) : 8 - int'(u)) : 0;
    e.lat   = e.steps * DWELL + 1;
    m_ptr   = ~w;
    m_pos   = e.pos;
  endtask

  task automatic wait_done(output logic [1:0] d, output logic [3:0] p,
                           output int lat, output int ns, output bit to);
    d = 2'b00; p = 4'd0; lat = 0; ns = 0; to = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (step) ns++;
      if (done != 2'b00) begin
        d = done; p = pos; lat = i; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    m_pos = RESET_POS;
    m_ptr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 2'b11;
    tgt0 = 4'd3;
    tgt1 = 4'd5;
    tick();
    tick();
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00 || err !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ctl: grant=%b busy=%b done=%b err=%b want 00 0 00 00",
               grant, busy, done, err);
    end
    vectors++;
    if (pos !== RESET_POS || dir !== 1'b1 || step !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pos: pos=%0d dir=%b step=%b want %0d 1 0",
               pos, dir, step, RESET_POS);
    end
    req = 2'b00;
    rst = 1'b1;
    m_pos = RESET_POS;
    m_ptr = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    exp_t o;
    tgt0 = 4'd7;
    tgt1 = 4'd2;
    req = 2'b01;
    predict(req, tgt0, tgt1, e);
    sbq.push_back(e);
    tick();
    req = 2'b00;
    vectors++;
    if (grant !== 2'b01 || dir !== 1'b1 || busy !== 1'b1 || pos !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_grant: grant=%b dir=%b busy=%b pos=%0d want 01 1 1 1",
               grant, dir, busy, pos);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 0 && i <= 6) begin
        vectors++;
        if (pos !== 4'(1 + i) || step !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_step edge N+%0d: pos=%0d step=%b want %0d 1",
                   i, pos, step, 1 + i);
        end
      end
      if (i == 7) begin
        o = sbq.pop_front();
        vectors++;
        if (done !== o.grant || pos !== o.pos || grant !== 2'b01) begin
          miscompares++;
          $display("FAIL basic_done: done=%b pos=%0d grant=%b want %b %0d 01",
                   done, pos, grant, o.grant, o.pos);
        end
      end
    end
    vectors++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_release: grant=%b done=%b busy=%b want 00 00 0",
               grant, done, busy);
    end
  endtask

  localparam logic [1:0] R_TAB [7] = '{2'b01, 2'b10, 2'b01, 2'b01,
                                       2'b10, 2'b01, 2'b01};
  localparam logic [3:0] T0_TAB [7] = '{4'd15, 4'd6, 4'd1, 4'd11,
                                        4'd6, 4'd9, 4'd9};
  localparam logic [3:0] T1_TAB [7] = '{4'd6, 4'd3, 4'd6, 4'd6,
                                        4'd1, 4'd6, 4'd6};

  // Wrap up, wrap down, distance-5 down, tie at 4, and zero distance.
  task automatic test_seeks();
    exp_t       e;
    exp_t       o;
    logic [1:0] d;
    logic [3:0] p;
    int         lat;
    int         ns;
    bit         to;
    for (int k = 0; k < 7; k++) begin
      tgt0 = T0_TAB[k];
      tgt1 = T1_TAB[k];
      req = R_TAB[k];
      predict(req, tgt0, tgt1, e);
      sbq.push_back(e);
      tick();
      req = 2'b00;
      tgt0 = 4'd5;
      tgt1 = 4'd5;
      vectors++;
      if (grant !== e.grant || (e.steps > 0 && dir !== e.dir)) begin
        miscompares++;
        $display("FAIL seek%0d_grant: grant=%b dir=%b want %b %b",
                 k, grant, dir, e.grant, e.dir);
      end
      wait_done(d, p, lat, ns, to);
      o = sbq.pop_front();
      vectors++;
      if (to || d !== o.grant || p !== o.pos) begin
        miscompares++;
        $display("FAIL seek%0d_done: timeout=%b done=%b pos=%0d want %b %0d",
                 k, to, d, p, o.grant, o.pos);
      end
      vectors++;
      if (lat !== o.lat || ns !== o.steps) begin
        miscompares++;
        $display("FAIL seek%0d_timing: lat=%0d steps=%0d want %0d %0d",
                 k, lat, ns, o.lat, o.steps);
      end
      tick();
      vectors++;
      if (grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
        miscompares++;
        $display("FAIL seek%0d_release: grant=%b busy=%b done=%b want 00 0 00",
                 k, grant, busy, done);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t       e;
    exp_t       o;
    logic [1:0] d;
    logic [3:0] p;
    int         lat;
    int         ns;
    bit         to;
    bit         seen;
    apply_reset();
    tgt0 = 4'd3;
    tgt1 = 4'd5;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      predict(req, tgt0, tgt1, e);
      sbq.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        tick();
        if (grant != 2'b00) seen = 1'b1;
      end
      vectors++;
      if (!seen || grant !== e.grant) begin
        miscompares++;
        $display("FAIL rr%0d_grant: seen=%b grant=%b want %b",
                 k, seen, grant, e.grant);
      end
      wait_done(d, p, lat, ns, to);
      o = sbq.pop_front();
      vectors++;
      if (to || d !== o.grant || p !== o.pos || lat !== o.lat) begin
        miscompares++;
        $display("FAIL rr%0d_done: timeout=%b done=%b pos=%0d lat=%0d want %b %0d %0d",
                 k, to, d, p, lat, o.grant, o.pos, o.lat);
      end
      tick();
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_even();
    exp_t       e;
    exp_t       o;
    logic [1:0] d;
    logic [3:0] p;
    int         lat;
    int         ns;
    bit         to;
    apply_reset();
    tgt0 = 4'd4;
    tgt1 = 4'd7;
    req = 2'b01;
    predict(req, tgt0, tgt1, e);
    tick();
    req = 2'b00;
    vectors++;
    if (err !== 2'b01 || grant !== 2'b00 || busy !== 1'b0 || pos !== e.pos) begin
      miscompares++;
      $display("FAIL even_err: err=%b grant=%b busy=%b pos=%0d want 01 00 0 %0d",
               err, grant, busy, pos, e.pos);
    end
    tick();
    vectors++;
    if (err !== 2'b00 || pos !== e.pos || step !== 1'b0) begin
      miscompares++;
      $display("FAIL even_pulse: err=%b pos=%0d step=%b want 00 %0d 0",
               err, pos, step, e.pos);
    end
    req = 2'b11;
    predict(req, tgt0, tgt1, e);
    sbq.push_back(e);
    tick();
    req = 2'b00;
    vectors++;
    if (grant !== e.grant) begin
      miscompares++;
      $display("FAIL even_ptr: grant=%b want %b", grant, e.grant);
    end
    wait_done(d, p, lat, ns, to);
    o = sbq.pop_front();
    vectors++;
    if (to || d !== o.grant || p !== o.pos || ns !== o.steps) begin
      miscompares++;
      $display("FAIL even_next_done: timeout=%b done=%b pos=%0d steps=%0d want %b %0d %0d",
               to, d, p, ns, o.grant, o.pos, o.steps);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit stray;
    tgt0 = 4'd13;
    tgt1 = 4'd6;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_pos = RESET_POS;
    m_ptr = 1'b0;
    vectors++;
    if (pos !== RESET_POS || grant !== 2'b00 || busy !== 1'b0 ||
        dir !== 1'b1 || step !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: pos=%0d grant=%b busy=%b dir=%b step=%b want %0d 00 0 1 0",
               pos, grant, busy, dir, step, RESET_POS);
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done != 2'b00 || pos != RESET_POS) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: done or pos moved after abort, got %b want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seeks();
    test_simultaneous();
    test_even();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/odd_seek_arbiter.md
Name: odd_seek_arbiter

Overview:
- Owns a shared odd-valued 4-bit position register that holds one of 1,3,...,15 and wraps in both directions.
- Two requesters each ask to move the position to a target value. The block arbitrates between them round-robin.
- It then steps the position one odd value per dwell period, in the shortest direction, until the target is reached, and signals completion.
- It is the sequencer and arbiter that sits in front of the odd up/down counting datapath.

Parameters:
- RESET_POS, 4'b0001, position after reset; must be odd.
- DWELL, 2, clock cycles per step; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- req  in  2  request per requester; req[i] is level, sampled only in IDLE
- tgt0  in  4  target for requester 0; sampled with its grant
- tgt1  in  4  target for requester 1; sampled with its grant
- grant  out  2  one-hot owner of the position; 0 when idle
- busy  out  1  high whenever state ≠ IDLE
- done  out  2  one-cycle pulse to the served requester on arrival
- err  out  2  one-cycle pulse when the winning target is even
- pos  out  4  current position; always odd
- dir  out  1  direction of the current seek: 1 = up (+2), 0 = down (−2)
- step  out  1  one-cycle pulse in the cycle after pos changed

Behaviour:
- Reset (rst=0 at a clk edge):
  - pos=RESET_POS, state=IDLE.
  - grant, done, err, step, busy all 0; dir=1.
  - Round-robin pointer favours requester 0; dwell counter=0.
  - Reset overrides everything, including a seek in progress; the target is discarded.
- Position arithmetic:
  - Up: 15→1, else +2. Down: 1→15, else −2.
  - Index k=pos[3:1]; up-distance u=(tk−pk) mod 8.
  - u=0: no motion. 1≤u≤4: up (a tie at 4 goes up). u≥5: down, 8−u steps.
- IDLE:
  - If any req is high, pick a winner: the sole requester, or if both are high, the one the pointer favours. Latch its target.
  - Pointer then favours the other requester.
  - Winner's target even (bit0=0): err[winner]=1 for the next cycle, no grant, stay IDLE.
  - Otherwise, at that edge: grant[winner]=1, dir set per distance rule, dwell=0, state=SEEK.
- SEEK, each edge:
  - If pos==target → state DONE, done[winner]=1 in that cycle.
  - Else if dwell==DWELL−1 → pos stepped per dir, dwell=0, step=1 next cycle.
  - Else dwell+1.
  - req and tgt changes are ignored during SEEK; a seek cannot be cancelled except by reset.
- DONE:
  - Lasts one cycle with grant still high.
  - Next edge: grant=0, done=0, state=IDLE. Arbitration resumes in that IDLE cycle.
- Latency: req sampled at edge N with distance d steps.
  - Grant is visible after edge N.
  - Last step at edge N+d·DWELL.
  - done visible after edge N+d·DWELL+1.
  - grant drops after edge N+d·DWELL+2.
  - d=0: done after edge N+1.
- A requester that keeps req high after done re-competes. If the other requester is also waiting, the other requester wins.
- pos only changes in SEEK, and never changes in IDLE, DONE or when err is issued.

Test Plan:
- Reset, then req=01, tgt0=7, DWELL=2 → grant=01 after edge N; dir=1; pos 1→3→5→7 at edges N+2, N+4, N+6; done=01 after N+7; grant=00 after N+8.
- Wrap-around up: pos=15, req1 tgt1=3 → dir=1; pos 15→1→3 (u=2); done=10. Down path: pos=1, tgt0=11 (u=5) → dir=0; pos 1→15→13→11; done after 3 steps.
- Tie and zero distance: pos=1, tgt0=9 (u=4) → dir=1, 4 steps up. Then tgt0=9 at pos=9 → done one cycle after grant; no step pulse.
- Simultaneous requests: req=11 after reset → requester 0 served first. With req1 still held, next IDLE grants 10; with req=11 held throughout, grants alternate 01, 10, 01.
- Even target: req=01, tgt0=4 → err=01 for one cycle; grant stays 00; pos unchanged; pointer now favours requester 1.
- Reset mid-seek: assert rst=0 during SEEK toward 13 → after that edge pos=RESET_POS, grant=00, busy=0; no done pulse is ever issued for the aborted seek.
